mem_access_stage: RTL and testbench

- Memory stage of the pipelined CPU. Consumes the EX/MEM register outputs (…M signals) and drives the data-memory bus with a req/gnt/rvalid handshake.
- Performs byte-lane alignment and load extension.
- Registers results into the MEM/WB boundary (…W signals).
- Raises StallM to the hazard unit while a bus access is outstanding. The hazard unit then freezes EX/MEM and earlier stages.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/load_store_align.sv | 76 +++++++
 rtl/mem_access_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access pipeline stage:
//   - state_t      : bus-access FSM states
//   - SZ_*         : access-size codes carried in CtrlM[1:0]
//   - CTRL_*       : bit positions of the fields inside CtrlM
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  // Access size codes; 2'b11 is handled exactly like a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // CtrlM field positions. Bits above CTRL_UNS carry no meaning here.
  localparam int CTRL_SZ_LO = 0;
  localparam int CTRL_SZ_HI = 1;
  localparam int CTRL_UNS   = 2;

endpackage

// File: rtl/load_store_align.sv
// ---------------------------------------------------------------------------
// load_store_align
// Purely combinational byte-lane logic for a 32-bit little-endian bus.
//
// Ports:
//   size_i       in  2   access size code (SZ_BYTE / SZ_HALF / word)
//   uns_i        in  1   1 = zero-extend loads, 0 = sign-extend
//   addr_i       in  2   low address bits (lane offset)
//   wdata_i      in  32  raw store data (operand in the low bits)
//   rdata_i      in  32  raw word returned by the bus
//   be_o         out 4   store byte enables
//   wdata_o      out 32  store data replicated onto every candidate lane
//   misaligned_o out 1   access crosses its natural alignment
//   rdata_o      out 32  selected and extended load data
// ---------------------------------------------------------------------------
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Split the returned word into its four byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  assign sel_byte = lane[addr_i];
  // Only even offsets reach a completed half load; addr_i[0] is flagged as
  // misaligned before the bus is touched.
  assign sel_half = addr_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  // Store side: replicate the operand so whichever lane is enabled already
  // carries the right bytes.
  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << addr_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      default: begin
        misaligned_o = |addr_i;
      end
    endcase
  end

  // Load side: lane select plus sign/zero extension.
  always_comb begin
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{~uns_i & sel_byte[7]}}, sel_byte};
      SZ_HALF: rdata_o = {{16{~uns_i & sel_half[15]}}, sel_half};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// Memory stage of the pipelined CPU. Takes the EX/MEM outputs (...M),
// performs data-memory accesses over a req/gnt/rvalid bus, and registers the
// results into the MEM/WB boundary (...W). State updates on the falling edge
// of CLK so the stage lines up with the surrounding pipeline registers.
//
// Ports:
//   CLK, RST_N                 clock (falling edge active), async low reset
//   PCSrcM, RegWriteM,
//   MemToRegM, MemWriteM       control from EX/MEM
//   WA3M [4:0]                 destination register
//   ALUOutM, WriteDataM        address / ALU result, store data
//   CtrlM [6:0]                [1:0] size, [2] unsigned load
//   MemReq, MemWe, MemAddr,
//   MemWData, MemBe            bus request side
//   MemGnt, MemRValid, MemRData bus response side
//   StallM                     access outstanding, freeze upstream stages
//   BusErrM                    one-cycle pulse: misaligned access or timeout
//   PCSrcW, RegWriteW,
//   MemToRegW, WA3W,
//   ALUOutW, ReadDataW         registered results towards WB
// ---------------------------------------------------------------------------
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            PCSrcM,
  input  logic            RegWriteM,
  input  logic            MemToRegM,
  input  logic            MemWriteM,
  input  logic [4:0]      WA3M,
  input  logic [SIZE-1:0] ALUOutM,
  input  logic [SIZE-1:0] WriteDataM,
  input  logic [6:0]      CtrlM,
  output logic            MemReq,
  output logic            MemWe,
  output logic [SIZE-1:0] MemAddr,
  output logic [SIZE-1:0] MemWData,
  output logic [3:0]      MemBe,
  input  logic            MemGnt,
  input  logic            MemRValid,
  input  logic [SIZE-1:0] MemRData,
  output logic            StallM,
  output logic            BusErrM,
  output logic            PCSrcW,
  output logic            RegWriteW,
  output logic            MemToRegW,
  output logic [4:0]      WA3W,
  output logic [SIZE-1:0] ALUOutW,
  output logic [SIZE-1:0] ReadDataW
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pcsrc_w_q, pcsrc_w_d;
  logic            regwrite_w_q, regwrite_w_d;
  logic            memtoreg_w_q, memtoreg_w_d;
  logic [4:0]      wa3_w_q, wa3_w_d;
  logic [SIZE-1:0] aluout_w_q, aluout_w_d;
  logic [SIZE-1:0] readdata_w_q, readdata_w_d;

  logic            mem_op;
  logic            timed_out;
  logic            req;
  logic            stall;
  logic            bus_err;
  logic            capture;
  logic            load_done;

  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic            misaligned;
  logic [31:0]     ld_data;

  logic            unused_ctrl;
  assign unused_ctrl = ^CtrlM[6:3];

  assign mem_op    = MemWriteM | MemToRegM;
  assign timed_out = (cnt_q == CW'(TIMEOUT));

  load_store_align u_align (
    .size_i       (CtrlM[CTRL_SZ_HI:CTRL_SZ_LO]),
    .uns_i        (CtrlM[CTRL_UNS]),
    .addr_i       (ALUOutM[1:0]),
    .wdata_i      (WriteDataM),
    .rdata_i      (MemRData),
    .be_o         (st_be),
    .wdata_o      (st_wdata),
    .misaligned_o (misaligned),
    .rdata_o      (ld_data)
  );

  // Next-state and Mealy outputs. "capture" means the W registers take the
  // M inputs on the coming edge; otherwise they take a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    stall     = 1'b0;
    bus_err   = 1'b0;
    capture   = 1'b0;
    load_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          capture = 1'b1;
        end else if (misaligned) begin
          bus_err = 1'b1;
        end else begin
          req = 1'b1;
          if (MemGnt) begin
            if (MemWriteM) begin
              capture = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = WAIT_DATA;
            end
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (timed_out) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          req = 1'b1;
          if (MemGnt) begin
            // A same-cycle MemRValid is deliberately ignored here; data for a
            // load is only accepted once the grant has moved us on.
            if (MemWriteM) begin
              capture = 1'b1;
              state_d = IDLE;
            end else begin
              stall   = 1'b1;
              state_d = WAIT_DATA;
            end
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      WAIT_DATA: begin
        if (timed_out) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else if (MemRValid) begin
          capture   = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The timeout counter measures time spent in the current state only.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pcsrc_w_d    = capture & PCSrcM;
    regwrite_w_d = capture & RegWriteM;
    memtoreg_w_d = capture & MemToRegM;
    wa3_w_d      = capture ? WA3M : 5'd0;
    aluout_w_d   = capture ? ALUOutM : '0;
    readdata_w_d = load_done ? ld_data : '0;
  end

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pcsrc_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      wa3_w_q      <= 5'd0;
      aluout_w_q   <= '0;
      readdata_w_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pcsrc_w_q    <= pcsrc_w_d;
      regwrite_w_q <= regwrite_w_d;
      memtoreg_w_q <= memtoreg_w_d;
      wa3_w_q      <= wa3_w_d;
      aluout_w_q   <= aluout_w_d;
      readdata_w_q <= readdata_w_d;
    end
  end

  // The Mealy outputs are qualified with RST_N so a request or error pulse
  // vanishes the moment reset asserts, whatever the M inputs are doing.
  assign MemReq   = req & RST_N;
  assign MemWe    = req & RST_N & MemWriteM;
  assign StallM   = stall & RST_N;
  assign BusErrM  = bus_err & RST_N;
  assign MemAddr  = {ALUOutM[SIZE-1:2], 2'b00};
  assign MemBe    = MemWriteM ? st_be : 4'b1111;
  assign MemWData = st_wdata;

  assign PCSrcW    = pcsrc_w_q;
  assign RegWriteW = regwrite_w_q;
  assign MemToRegW = memtoreg_w_q;
  assign WA3W      = wa3_w_q;
  assign ALUOutW   = aluout_w_q;
  assign ReadDataW = readdata_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench: a behavioural model checks every cycle, directed
// transactions pin literal values, randomized instructions and bus responses
// exercise the rest.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PCSrcM, RegWriteM, MemToRegM, MemWriteM;
  logic [4:0]  WA3M;
  logic [31:0] ALUOutM, WriteDataM;
  logic [6:0]  CtrlM;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBe;
  logic        MemGnt, MemRValid;
  logic [31:0] MemRData;
  logic        StallM, BusErrM;
  logic        PCSrcW, RegWriteW, MemToRegW;
  logic [4:0]  WA3W;
  logic [31:0] ALUOutW, ReadDataW;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.SIZE(32), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .WA3M(WA3M), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .CtrlM(CtrlM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe),
    .MemGnt(MemGnt), .MemRValid(MemRValid), .MemRData(MemRData),
    .StallM(StallM), .BusErrM(BusErrM),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .WA3W(WA3W), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and W outputs are observed just after the active (falling)
  // edge.
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic pcs, input logic rw, input logic mtr, input logic mw,
                           input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [6:0] ctrl);
    PCSrcM = pcs; RegWriteM = rw; MemToRegM = mtr; MemWriteM = mw;
    WA3M = wa; ALUOutM = alu; WriteDataM = wd; CtrlM = ctrl;
  endtask

  task automatic nop();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 7'd0);
    MemGnt = 1'b0; MemRValid = 1'b0; MemRData = 32'd0;
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [1:0] lane,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] s, v;
    s = rd >> (8 * int'(lane));
    if (sz == 2'd0) begin
      v = s & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = s & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] lane);
    if (sz == 2'd0) return 4'(1 << int'(lane));
    if (sz == 2'd1) return 4'(3 << int'(lane));
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  logic        model_on = 1'b0;
  logic        exp_stall = 1'b0;

  // Model: ph = 0 nothing pending, 1 waiting for a grant, 2 waiting for data;
  // waited = unanswered cycles spent in the current waiting phase.
  initial begin : model
    int          ph, waited;
    logic        p_pcs, p_rw, p_mtr, p_cap;
    logic [4:0]  p_wa;
    logic [31:0] p_alu, p_rd;
    logic [1:0]  sz, lane;
    logic        mis, mem, e_req, e_stall, e_err, cap, cap_load;
    ph = 0; waited = 0;
    p_pcs = 0; p_rw = 0; p_mtr = 0; p_cap = 0; p_wa = 0; p_alu = 0; p_rd = 0;
    forever begin
      @(posedge CLK);
      if (model_on) begin
        if (!RST_N) begin
          chk("rst_MemReq", 32'(MemReq), 32'd0);
          chk("rst_StallM", 32'(StallM), 32'd0);
          chk("rst_BusErrM", 32'(BusErrM), 32'd0);
          chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
          chk("rst_MemToRegW", 32'(MemToRegW), 32'd0);
          chk("rst_PCSrcW", 32'(PCSrcW), 32'd0);
          chk("rst_WA3W", 32'(WA3W), 32'd0);
          chk("rst_ALUOutW", ALUOutW, 32'd0);
          chk("rst_ReadDataW", ReadDataW, 32'd0);
          ph = 0; waited = 0; exp_stall = 0;
          p_pcs = 0; p_rw = 0; p_mtr = 0; p_cap = 0; p_wa = 0; p_alu = 0; p_rd = 0;
        end else begin
          // W outputs reflect the decision made one cycle ago.
          chk("m_PCSrcW", 32'(PCSrcW), 32'(p_pcs));
          chk("m_RegWriteW", 32'(RegWriteW), 32'(p_rw));
          chk("m_MemToRegW", 32'(MemToRegW), 32'(p_mtr));
          chk("m_ReadDataW", ReadDataW, p_rd);
          if (p_cap) begin
            chk("m_WA3W", 32'(WA3W), 32'(p_wa));
            chk("m_ALUOutW", ALUOutW, p_alu);
          end

          sz = CtrlM[1:0];
          lane = ALUOutM[1:0];
          mem = MemWriteM | MemToRegM;
          mis = (sz == 2'd1 && lane[0]) || (sz >= 2'd2 && lane != 2'd0);
          e_req = 0; e_stall = 0; e_err = 0; cap = 0; cap_load = 0;
          if (ph == 0) begin
            if (!mem) cap = 1;
            else if (mis) e_err = 1;
            else begin
              e_req = 1;
              if (MemGnt && MemWriteM) cap = 1;
              else if (MemGnt) begin e_stall = 1; ph = 2; waited = 0; end
              else begin e_stall = 1; ph = 1; waited = 0; end
            end
          end else if (waited == TIMEOUT) begin
            e_err = 1; ph = 0;
          end else if (ph == 1) begin
            e_req = 1;
            if (MemGnt && MemWriteM) begin cap = 1; ph = 0; end
            else if (MemGnt) begin e_stall = 1; ph = 2; waited = 0; end
            else begin e_stall = 1; waited++; end
          end else begin
            if (MemRValid) begin cap = 1; cap_load = 1; ph = 0; end
            else begin e_stall = 1; waited++; end
          end

          chk("m_MemReq", 32'(MemReq), 32'(e_req));
          chk("m_StallM", 32'(StallM), 32'(e_stall));
          chk("m_BusErrM", 32'(BusErrM), 32'(e_err));
          if (e_req) begin
            chk("m_MemWe", 32'(MemWe), 32'(MemWriteM));
            chk("m_MemAddr", MemAddr, ALUOutM & ~32'd3);
            chk("m_MemBe", 32'(MemBe), 32'(MemWriteM ? f_be(sz, lane) : 4'hF));
            if (MemWriteM) chk("m_MemWData", MemWData, f_wd(sz, WriteDataM));
          end
          exp_stall = e_stall;

          p_cap = cap;
          p_pcs = cap & PCSrcM;
          p_rw  = cap & RegWriteM;
          p_mtr = cap & MemToRegM;
          p_wa  = cap ? WA3M : 5'd0;
          p_alu = cap ? ALUOutM : 32'd0;
          p_rd  = cap_load ? f_load(MemRData, lane, sz, CtrlM[2]) : 32'd0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_half(input logic uns, input logic [31:0] expv);
    int  stalls;
    bit  fin;
    stalls = 0; fin = 0;
    set_instr(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h202, 32'd0, {4'b0, uns, 2'b01});
    MemRData = 32'h8001_0000;
    for (int k = 0; k < 30 && !fin; k++) begin
      MemGnt = (k == 2);
      MemRValid = (k == 5);
      #1;
      if (StallM) stalls++;
      else fin = 1;
      step();
    end
    chk("lh_retired", 32'(fin), 32'd1);
    chk("lh_stall_cycles", 32'(stalls), 32'd5);
    chk("lh_ReadDataW", ReadDataW, expv);
    chk("lh_RegWriteW", 32'(RegWriteW), 32'd1);
    $display("txn load_half uns=%0d stalls=%0d ReadDataW=%08h", uns, stalls, ReadDataW);
    nop();
  endtask

  initial begin : stim
    int   stalls, cyc, kind, mode;
    bit   fin;
    nop();
    // Reset with an aligned store presented: the request must stay low.
    set_instr(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h100, 32'h55, 7'd2);
    step(); step();
    chk("reset_MemReq", 32'(MemReq), 32'd0);
    chk("reset_StallM", 32'(StallM), 32'd0);
    chk("reset_BusErrM", 32'(BusErrM), 32'd0);
    chk("reset_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset_ALUOutW", ALUOutW, 32'd0);
    model_on = 1'b1;
    nop();
    RST_N = 1'b1;
    step();

    // ALU op passes straight through.
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0, 7'd0);
    #1 chk("alu_StallM", 32'(StallM), 32'd0);
    step();
    chk("alu_RegWriteW", 32'(RegWriteW), 32'd1);
    chk("alu_WA3W", 32'(WA3W), 32'd5);
    chk("alu_ALUOutW", ALUOutW, 32'h1234);
    $display("txn alu WA3W=%0d ALUOutW=%08h", WA3W, ALUOutW);
    nop();

    // Store byte at offset 3, granted immediately.
    set_instr(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h103, 32'hAB, 7'd0);
    MemGnt = 1'b1;
    #1;
    chk("sb_MemReq", 32'(MemReq), 32'd1);
    chk("sb_MemWe", 32'(MemWe), 32'd1);
    chk("sb_MemBe", 32'(MemBe), 32'b1000);
    chk("sb_MemWData", MemWData, 32'hABABABAB);
    chk("sb_MemAddr", MemAddr, 32'h100);
    chk("sb_StallM", 32'(StallM), 32'd0);
    $display("txn store_byte MemBe=%b MemWData=%08h", MemBe, MemWData);
    step();
    nop();

    load_half(1'b0, 32'hFFFF8001);
    load_half(1'b1, 32'h00008001);

    // Misaligned word load.
    set_instr(1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h001, 32'd0, 7'd2);
    #1;
    chk("mis_MemReq", 32'(MemReq), 32'd0);
    chk("mis_BusErrM", 32'(BusErrM), 32'd1);
    chk("mis_StallM", 32'(StallM), 32'd0);
    step();
    chk("mis_RegWriteW", 32'(RegWriteW), 32'd0);
    $display("txn misaligned_load RegWriteW=%0d", RegWriteW);
    nop();

    // Granted load that never returns data.
    set_instr(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h40, 32'd0, 7'd2);
    stalls = 0; fin = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      MemGnt = (k == 0);
      MemRValid = 1'b0;
      #1;
      if (StallM) stalls++;
      else begin
        chk("to_BusErrM", 32'(BusErrM), 32'd1);
        fin = 1;
      end
      step();
    end
    chk("to_retired", 32'(fin), 32'd1);
    chk("to_stall_cycles", 32'(stalls), 32'(TIMEOUT + 1));
    chk("to_RegWriteW", 32'(RegWriteW), 32'd0);
    nop();
    #1;
    chk("to_BusErrM_pulse_end", 32'(BusErrM), 32'd0);
    chk("to_StallM_idle", 32'(StallM), 32'd0);
    $display("txn load_timeout stalls=%0d", stalls);
    step();

    // Reset while waiting for load data; a late rvalid must not write.
    set_instr(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h80, 32'd0, 7'd2);
    MemGnt = 1'b1;
    step();
    MemGnt = 1'b0;
    step();
    #2 RST_N = 1'b0;
    #1;
    chk("rstw_StallM", 32'(StallM), 32'd0);
    chk("rstw_MemReq", 32'(MemReq), 32'd0);
    chk("rstw_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rstw_ReadDataW", ReadDataW, 32'd0);
    step();
    RST_N = 1'b1;
    MemRValid = 1'b1;
    MemRData = 32'hDEADBEEF;
    step();
    chk("late_rvalid_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("late_rvalid_ReadDataW", ReadDataW, 32'd0);
    $display("txn reset_in_wait RegWriteW=%0d", RegWriteW);
    RST_N = 1'b0;
    nop();
    step();
    RST_N = 1'b1;
    step();

    // Randomized instructions with a randomized bus.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      set_instr(1'($urandom), 1'($urandom), kind == 2, kind == 1, 5'($urandom),
                $urandom, $urandom, 7'($urandom));
      if (kind != 0 && $urandom_range(0, 3) != 0) begin
        if (CtrlM[1:0] == 2'd1) ALUOutM[0] = 1'b0;
        else if (CtrlM[1:0] >= 2'd2) ALUOutM[1:0] = 2'b00;
      end
      mode = $urandom_range(0, 9);
      fin = 0; cyc = 0;
      while (!fin && cyc < 40) begin
        MemGnt    = (mode == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
        MemRValid = (mode == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
        MemRData  = $urandom;
        @(posedge CLK);
        #1;
        fin = !exp_stall;
        step();
        cyc++;
      end
      chk("rand_retired", 32'(fin), 32'd1);
      $display("txn %0d kind=%0d addr=%08h ctrl=%02h cycles=%0d", n, kind, ALUOutM, CtrlM, cyc);
    end

    nop();
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
